// File: rtl/vip_edge_bbox_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : vip_edge_bbox_detector                                         |
// | Brief   : Per-frame bounding box and pixel count of a 1-bit edge stream. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vip_edge_bbox_detector #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int MIN_PIXELS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        per_frame_vsync,
   input  logic        per_frame_href,
   input  logic        per_frame_clken,
   input  logic        per_img_Bit,
   output logic [11:0] bbox_x_min,
   output logic [11:0] bbox_x_max,
   output logic [11:0] bbox_y_min,
   output logic [11:0] bbox_y_max,
   output logic [23:0] edge_count,
   output logic        bbox_valid,
   output logic        frame_done,
   output logic [7:0]  frame_cnt
);

   localparam logic [11:0] c_WIDTH   = 12'(IMG_WIDTH);
   localparam logic [11:0] c_HEIGHT  = 12'(IMG_HEIGHT);
   localparam logic [23:0] c_MIN     = 24'(MIN_PIXELS);
   localparam logic [23:0] c_CNT_MAX = 24'hFFFFFF;

   logic        vsync_q, href_q;
   logic [11:0] col_q, col_d, row_q, row_d;
   logic [11:0] acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
   logic [11:0] acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
   logic [23:0] acc_cnt_q, acc_cnt_d;
   logic [11:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
   logic [23:0] ecnt_q, ecnt_d;
   logic        valid_q, valid_d, done_q, done_d;
   logic [7:0]  fcnt_q, fcnt_d;

   logic w_line_end, w_frame_end, w_hit, w_valid;

   assign w_line_end  = href_q & ~per_frame_href;
   assign w_frame_end = vsync_q & ~per_frame_vsync;
   assign w_hit       = per_frame_vsync & per_frame_href & per_frame_clken & per_img_Bit
                      & (col_q < c_WIDTH) & (row_q < c_HEIGHT);
   assign w_valid     = (acc_cnt_q >= c_MIN);

   // Counters saturate at the image size so clipped pixels can never qualify.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (!per_frame_vsync) begin
         col_d = '0;
         row_d = '0;
      end else begin
         if (w_line_end)
            col_d = '0;
         else if (per_frame_href && per_frame_clken && (col_q < c_WIDTH))
            col_d = col_q + 12'd1;
         if (w_line_end && (row_q < c_HEIGHT))
            row_d = row_q + 12'd1;
      end
   end

   always_comb begin
      acc_xmin_d = acc_xmin_q;
      acc_xmax_d = acc_xmax_q;
      acc_ymin_d = acc_ymin_q;
      acc_ymax_d = acc_ymax_q;
      acc_cnt_d  = acc_cnt_q;
      if (w_frame_end) begin
         acc_xmin_d = 12'hFFF;
         acc_xmax_d = '0;
         acc_ymin_d = 12'hFFF;
         acc_ymax_d = '0;
         acc_cnt_d  = '0;
      end else if (w_hit) begin
         if (col_q < acc_xmin_q) acc_xmin_d = col_q;
         if (col_q > acc_xmax_q) acc_xmax_d = col_q;
         if (row_q < acc_ymin_q) acc_ymin_d = row_q;
         if (row_q > acc_ymax_q) acc_ymax_d = row_q;
         if (acc_cnt_q != c_CNT_MAX) acc_cnt_d = acc_cnt_q + 24'd1;
      end
   end

   always_comb begin
      xmin_d  = xmin_q;
      xmax_d  = xmax_q;
      ymin_d  = ymin_q;
      ymax_d  = ymax_q;
      ecnt_d  = ecnt_q;
      valid_d = valid_q;
      fcnt_d  = fcnt_q;
      done_d  = w_frame_end;
      if (w_frame_end) begin
         xmin_d  = w_valid ? acc_xmin_q : '0;
         xmax_d  = w_valid ? acc_xmax_q : '0;
         ymin_d  = w_valid ? acc_ymin_q : '0;
         ymax_d  = w_valid ? acc_ymax_q : '0;
         ecnt_d  = acc_cnt_q;
         valid_d = w_valid;
         fcnt_d  = fcnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         acc_xmin_q <= 12'hFFF;
         acc_xmax_q <= '0;
         acc_ymin_q <= 12'hFFF;
         acc_ymax_q <= '0;
         acc_cnt_q  <= '0;
         xmin_q     <= '0;
         xmax_q     <= '0;
         ymin_q     <= '0;
         ymax_q     <= '0;
         ecnt_q     <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         fcnt_q     <= '0;
      end else begin
         vsync_q    <= per_frame_vsync;
         href_q     <= per_frame_href;
         col_q      <= col_d;
         row_q      <= row_d;
         acc_xmin_q <= acc_xmin_d;
         acc_xmax_q <= acc_xmax_d;
         acc_ymin_q <= acc_ymin_d;
         acc_ymax_q <= acc_ymax_d;
         acc_cnt_q  <= acc_cnt_d;
         xmin_q     <= xmin_d;
         xmax_q     <= xmax_d;
         ymin_q     <= ymin_d;
         ymax_q     <= ymax_d;
         ecnt_q     <= ecnt_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         fcnt_q     <= fcnt_d;
      end
   end

   assign bbox_x_min = xmin_q;
   assign bbox_x_max = xmax_q;
   assign bbox_y_min = ymin_q;
   assign bbox_y_max = ymax_q;
   assign edge_count = ecnt_q;
   assign bbox_valid = valid_q;
   assign frame_done = done_q;
   assign frame_cnt  = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vip_edge_bbox_detector.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_vip_edge_bbox_detector                                      |
// | Brief   : Bench for vip_edge_bbox_detector; four instances, one stream.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vip_edge_bbox_detector;

   localparam int NDUT = 4;

   typedef struct {
      int w, h, sparse, full, gap, np;
      int px0, py0, px1, py1, px2, py2;
      int bc, bx0, bx1, by0, by1;
      int cc, cx0, cx1, cy0, cy1;
   } vec_t;

   typedef struct {
      int bc, bx0, bx1, by0, by1;
      int cc, cx0, cx1, cy0, cy1;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic vs = 1'b0, hr = 1'b0, ce = 1'b0, bt = 1'b0;
   always #5 clk = ~clk;

   logic [11:0] xmin [NDUT], xmax [NDUT], ymin [NDUT], ymax [NDUT];
   logic [23:0] ecnt [NDUT];
   logic        bval [NDUT], fdone [NDUT];
   logic [7:0]  fcnt [NDUT];

   // Instances 0..2 are full size with different thresholds; 3 is an 8x4 clipping instance.
   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      vip_edge_bbox_detector #(
         .IMG_WIDTH  ((g == 3) ? 8 : 640),
         .IMG_HEIGHT ((g == 3) ? 4 : 480),
         .MIN_PIXELS ((g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 16 : 1)
      ) u_dut (
         .clk             (clk),
         .rst_n           (rst_n),
         .per_frame_vsync (vs),
         .per_frame_href  (hr),
         .per_frame_clken (ce),
         .per_img_Bit     (bt),
         .bbox_x_min      (xmin[g]),
         .bbox_x_max      (xmax[g]),
         .bbox_y_min      (ymin[g]),
         .bbox_y_max      (ymax[g]),
         .edge_count      (ecnt[g]),
         .bbox_valid      (bval[g]),
         .frame_done      (fdone[g]),
         .frame_cnt       (fcnt[g])
      );
   end

   int   total = 0, bad = 0;
   exp_t sbq [$];
   vec_t tbl [5];

   function automatic int min_of(int i);
      return (i == 0) ? 1 : (i == 1) ? 3 : (i == 2) ? 16 : 1;
   endfunction

   task automatic chk(string nm, int idx, longint act, longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s dut%0d actual=%0d required=%0d", nm, idx, act, req);
      end
   endtask

   task automatic drive(input logic v, input logic h, input logic c, input logic b);
      @(posedge clk);
      #1;
      vs = v; hr = h; ce = c; bt = b;
   endtask

   function automatic logic is_edge(vec_t v, int x, int y);
      if (v.full != 0) return 1'b1;
      if (v.np > 0 && v.px0 == x && v.py0 == y) return 1'b1;
      if (v.np > 1 && v.px1 == x && v.py1 == y) return 1'b1;
      if (v.np > 2 && v.px2 == x && v.py2 == y) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int rowlen(vec_t v, int y);
      int l = 0;
      if (v.np > 0 && v.py0 == y && v.px0 + 1 > l) l = v.px0 + 1;
      if (v.np > 1 && v.py1 == y && v.px1 + 1 > l) l = v.px1 + 1;
      if (v.np > 2 && v.py2 == y && v.px2 + 1 > l) l = v.px2 + 1;
      return l;
   endfunction

   task automatic send_frame(vec_t v);
      exp_t e;
      drive(1, 0, 0, 0);
      for (int y = 0; y < v.h; y++) begin
         int len;
         len = (v.sparse != 0) ? rowlen(v, y) : v.w;
         if (len == 0) drive(1, 1, 0, 0);
         for (int x = 0; x < len; x++) begin
            if (v.gap != 0)
               for (int k = 0; k < 3 && $urandom_range(1) == 1; k++) drive(1, 1, 0, 0);
            drive(1, 1, 1, is_edge(v, x, y));
         end
         drive(1, 0, 0, 0);
      end
      e = '{v.bc, v.bx0, v.bx1, v.by0, v.by1, v.cc, v.cx0, v.cx1, v.cy0, v.cy1};
      sbq.push_back(e);
      drive(0, 0, 0, 0);
   endtask

   task automatic check_zero(string tag);
      for (int i = 0; i < NDUT; i++) begin
         chk({tag, "_xmin"}, i, xmin[i], 0);
         chk({tag, "_xmax"}, i, xmax[i], 0);
         chk({tag, "_ymin"}, i, ymin[i], 0);
         chk({tag, "_ymax"}, i, ymax[i], 0);
         chk({tag, "_count"}, i, ecnt[i], 0);
         chk({tag, "_valid"}, i, bval[i], 0);
         chk({tag, "_done"}, i, fdone[i], 0);
         chk({tag, "_fcnt"}, i, fcnt[i], 0);
      end
   endtask

   // Scoreboard: frame_done is expected the cycle after vsync is first sampled low.
   logic s1 = 1'b0, s2 = 1'b0;
   int   fc_exp = 0;
   always @(negedge clk) begin
      logic fexp;
      exp_t e;
      if (!rst_n) begin
         s1 = 1'b0; s2 = 1'b0; fc_exp = 0;
      end
      fexp = s2 & ~s1;
      if (fexp) begin
         if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_underflow dut0 actual=1 required=0");
         end else begin
            e = sbq.pop_front();
            fc_exp++;
            for (int i = 0; i < NDUT; i++) begin
               int cnt, x0, x1, y0, y1, vld;
               cnt = (i == 3) ? e.cc  : e.bc;
               x0  = (i == 3) ? e.cx0 : e.bx0;
               x1  = (i == 3) ? e.cx1 : e.bx1;
               y0  = (i == 3) ? e.cy0 : e.by0;
               y1  = (i == 3) ? e.cy1 : e.by1;
               vld = (cnt >= min_of(i)) ? 1 : 0;
               chk("count", i, ecnt[i], cnt);
               chk("valid", i, bval[i], vld);
               chk("xmin", i, xmin[i], vld ? x0 : 0);
               chk("xmax", i, xmax[i], vld ? x1 : 0);
               chk("ymin", i, ymin[i], vld ? y0 : 0);
               chk("ymax", i, ymax[i], vld ? y1 : 0);
               chk("fcnt", i, fcnt[i], fc_exp % 256);
            end
         end
      end
      for (int i = 0; i < NDUT; i++) chk("frame_done", i, fdone[i], fexp);
      if (rst_n) begin
         s2 = s1;
         s1 = vs;
      end
   end

   initial begin
      exp_t e;
      tbl[0] = '{8, 4, 0, 0, 0, 1,  5, 2, 0, 0, 0, 0,  1, 5, 5, 2, 2,  1, 5, 5, 2, 2};
      tbl[1] = '{640, 480, 1, 0, 0, 3,  10, 20, 600, 20, 300, 470,
                 3, 10, 600, 20, 470,  0, 0, 0, 0, 0};
      tbl[2] = '{10, 6, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0,  60, 0, 9, 0, 5,  32, 0, 7, 0, 3};
      tbl[3] = '{8, 4, 0, 0, 1, 1,  5, 2, 0, 0, 0, 0,  1, 5, 5, 2, 2,  1, 5, 5, 2, 2};
      tbl[4] = '{8, 4, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_zero("reset");

      // Back-to-back frames, one idle cycle apart.
      for (int k = 0; k < 5; k++) send_frame(tbl[k]);

      // One-cycle vsync glitch.
      drive(1, 0, 0, 0);
      e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      sbq.push_back(e);
      drive(0, 0, 0, 0);

      // Edge on the final vsync-high cycle counts; edge on the falling cycle does not.
      drive(1, 0, 0, 0);
      drive(1, 1, 1, 0);
      drive(1, 1, 1, 1);
      e = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
      sbq.push_back(e);
      drive(0, 1, 1, 1);
      repeat (3) drive(0, 0, 0, 0);

      // Reset in the middle of a frame after 100 edge pixels.
      drive(1, 0, 0, 0);
      repeat (100) drive(1, 1, 1, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0; vs = 1'b0; hr = 1'b0; ce = 1'b0; bt = 1'b0;
      @(negedge clk);
      check_zero("midreset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) drive(0, 0, 0, 0);
      send_frame(tbl[0]);
      repeat (4) drive(0, 0, 0, 0);

      chk("sb_drain", 0, sbq.size(), 0);
      for (int i = 0; i < NDUT; i++) chk("final_fcnt", i, fcnt[i], 1);
      for (int i = 0; i < NDUT; i++) chk("final_count", i, ecnt[i], 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
